// File: rtl/smg_pkg.sv
// Shared defaults for the seven-segment scan controller.
package smg_pkg;
   localparam int T1MS         = 50000;
   localparam int DEF_DIGITS   = 4;
   localparam int DEF_BRIGHT_W = 4;
endpackage

// File: rtl/smg_scan_ctrl_module_tick_gen.sv
// Per-digit slot counter: counts 0..SCAN_TICKS-1 and flags the last cycle.
module smg_tick_gen
   import smg_pkg::*;
#(
   parameter int SCAN_TICKS = T1MS
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);
   localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_TICKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/smg_scan_ctrl_module.sv
// Multiplexed digit scanner with frame-shadowed data, leading-zero blanking
// and PWM dimming. Outputs are registered from next-state values.
module smg_scan_ctrl_module
   import smg_pkg::*;
#(
   parameter int DIGITS     = DEF_DIGITS,
   parameter int SCAN_TICKS = T1MS,
   parameter int BRIGHT_W   = DEF_BRIGHT_W
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [4*DIGITS-1:0]   Number_Sig,
   input  logic [DIGITS-1:0]     Dp_Sig,
   input  logic                  Zero_Blank_En,
   input  logic [BRIGHT_W-1:0]   Brightness,
   output logic [3:0]            Number_Data,
   output logic                  Dp_Data,
   output logic [DIGITS-1:0]     Digit_Sel,
   output logic                  Frame_Start
);
   localparam int IW = $clog2(DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   logic                first_q;
   logic                tick, wrap, load;
   logic [IW-1:0]       idx_q, idx_d;
   logic [BRIGHT_W-1:0] pwm_q, pwm_d;
   logic [4*DIGITS-1:0] num_sh_q, num_sh_d;
   logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic                zb_sh_q, zb_sh_d;
   logic [DIGITS-1:0]   hi_zero;
   logic                blank, lit;
   logic [3:0]          nib;
   logic [3:0]          nd_d;
   logic                dp_d;
   logic [DIGITS-1:0]   sel_d;

   // first_q marks the first edge after reset: it forces a shadow load and
   // holds the slot counter so digit 0 gets a full slot.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) first_q <= 1'b1;
      else     first_q <= 1'b0;
   end

   smg_tick_gen #(.SCAN_TICKS(SCAN_TICKS)) u_tick (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (~first_q),
      .tick_o (tick)
   );

   assign wrap = tick && (idx_q == LAST_IDX);
   assign load = first_q || wrap;

   always_comb begin
      idx_d = idx_q;
      if (first_q || wrap) idx_d = '0;
      else if (tick)       idx_d = idx_q + IW'(1);
   end

   assign pwm_d    = pwm_q + BRIGHT_W'(1);
   assign num_sh_d = load ? Number_Sig    : num_sh_q;
   assign dp_sh_d  = load ? Dp_Sig        : dp_sh_q;
   assign zb_sh_d  = load ? Zero_Blank_En : zb_sh_q;

   // hi_zero[k]: shadow digits k..DIGITS-1 are all zero.
   always_comb begin
      hi_zero = '0;
      hi_zero[DIGITS-1] = (num_sh_d[4*(DIGITS-1) +: 4] == 4'd0);
      for (int k = DIGITS - 2; k >= 0; k--)
         hi_zero[k] = hi_zero[k+1] && (num_sh_d[4*k +: 4] == 4'd0);
   end

   always_comb begin
      nib = 4'd0;
      for (int k = 0; k < DIGITS; k++)
         if (idx_d == IW'(k)) nib = num_sh_d[4*k +: 4];
   end

   assign blank = zb_sh_d && (idx_d != '0) && hi_zero[idx_d];
   assign lit   = (&Brightness) || (pwm_d < Brightness);

   always_comb begin
      sel_d = '0;
      if (!blank && lit) sel_d[idx_d] = 1'b1;
      nd_d = blank ? 4'd0 : nib;
      dp_d = blank ? 1'b0 : dp_sh_d[idx_d];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx_q       <= '0;
         pwm_q       <= '0;
         num_sh_q    <= '0;
         dp_sh_q     <= '0;
         zb_sh_q     <= 1'b0;
         Number_Data <= 4'd0;
         Dp_Data     <= 1'b0;
         Digit_Sel   <= '0;
         Frame_Start <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         pwm_q       <= pwm_d;
         num_sh_q    <= num_sh_d;
         dp_sh_q     <= dp_sh_d;
         zb_sh_q     <= zb_sh_d;
         Number_Data <= nd_d;
         Dp_Data     <= dp_d;
         Digit_Sel   <= sel_d;
         Frame_Start <= load;
      end
   end
endmodule

// File: tb/tb_smg_scan_ctrl_module.sv
// Directed bench: frame vectors from a table plus reset, tearing and PWM sequences.
module tb_smg_scan_ctrl_module;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] Number_Sig = 16'h0;
   logic [3:0]  Dp_Sig = 4'h0;
   logic        Zero_Blank_En = 1'b0;
   logic [3:0]  Brightness = 4'hF;
   logic [3:0]  Number_Data, Number_Data32;
   logic        Dp_Data, Dp_Data32;
   logic [3:0]  Digit_Sel, Digit_Sel32;
   logic        Frame_Start, Frame_Start32;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   smg_scan_ctrl_module #(.DIGITS(4), .SCAN_TICKS(4), .BRIGHT_W(4)) u_dut (
      .CLK(CLK), .RST(RST), .Number_Sig(Number_Sig), .Dp_Sig(Dp_Sig),
      .Zero_Blank_En(Zero_Blank_En), .Brightness(Brightness),
      .Number_Data(Number_Data), .Dp_Data(Dp_Data),
      .Digit_Sel(Digit_Sel), .Frame_Start(Frame_Start));

   smg_scan_ctrl_module #(.DIGITS(4), .SCAN_TICKS(32), .BRIGHT_W(4)) u_dut32 (
      .CLK(CLK), .RST(RST), .Number_Sig(Number_Sig), .Dp_Sig(Dp_Sig),
      .Zero_Blank_En(Zero_Blank_En), .Brightness(Brightness),
      .Number_Data(Number_Data32), .Dp_Data(Dp_Data32),
      .Digit_Sel(Digit_Sel32), .Frame_Start(Frame_Start32));

   typedef struct {
      logic [15:0] num;
      logic [3:0]  dp;
      logic        zb;
      logic [3:0]  lit;
      logic [15:0] nd;
      logic [3:0]  edp;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Advance until a Frame_Start pulse is seen; a missing pulse is a failure.
   task automatic wait_fs(input string name);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (Frame_Start) begin
            seen = 1;
            break;
         end
      end
      chk({name, " frame_start_seen"}, 16'(seen), 16'd1);
   endtask

   function automatic logic [3:0] nib_of(input logic [15:0] v, input int k);
      return v[4*k +: 4];
   endfunction

   initial begin
      int gap;
      int on_cnt;
      int k;
      bit changed;
      logic [3:0] es;
      logic [3:0] nd_first;

      tbl[0] = '{16'h4321, 4'b0000, 1'b0, 4'b1111, 16'h4321, 4'b0000};
      tbl[1] = '{16'h8765, 4'b0000, 1'b0, 4'b1111, 16'h8765, 4'b0000};
      tbl[2] = '{16'h0050, 4'b0000, 1'b1, 4'b0011, 16'h0050, 4'b0000};
      tbl[3] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, 16'h0000, 4'b0000};
      tbl[4] = '{16'h4321, 4'b0100, 1'b0, 4'b1111, 16'h4321, 4'b0100};
      tbl[5] = '{16'h0050, 4'b1111, 1'b1, 4'b0011, 16'h0050, 4'b0011};
      tbl[6] = '{16'h0F0A, 4'b0000, 1'b1, 4'b0111, 16'h0F0A, 4'b0000};
      tbl[7] = '{16'h0000, 4'b1000, 1'b0, 4'b1111, 16'h0000, 4'b1000};

      // Reset state, before any clock edge
      #1 RST = 1'b1;
      #1;
      chk("rst sel", 16'(Digit_Sel), 16'h0);
      chk("rst nd", 16'(Number_Data), 16'h0);
      chk("rst dp", 16'(Dp_Data), 16'h0);
      chk("rst fs", 16'(Frame_Start), 16'h0);
      Number_Sig = 16'h4321;
      Brightness = 4'hF;
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST = 1'b0;
      step();
      chk("first fs", 16'(Frame_Start), 16'h1);
      chk("first sel", 16'(Digit_Sel), 16'h1);
      chk("first nd", 16'(Number_Data), 16'h1);
      gap = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         gap++;
         if (Frame_Start) break;
      end
      chk("fs period", 16'(gap), 16'd16);

      // Table of whole-frame vectors
      for (int v = 0; v < 8; v++) begin
         Number_Sig    = tbl[v].num;
         Dp_Sig        = tbl[v].dp;
         Zero_Blank_En = tbl[v].zb;
         wait_fs($sformatf("vec%0d", v));
         for (int c = 0; c < 16; c++) begin
            k  = c / 4;
            es = '0;
            if (tbl[v].lit[k]) es[k] = 1'b1;
            chk($sformatf("vec%0d c%0d sel", v, c), 16'(Digit_Sel), 16'(es));
            chk($sformatf("vec%0d c%0d nd", v, c), 16'(Number_Data), 16'(nib_of(tbl[v].nd, k)));
            chk($sformatf("vec%0d c%0d dp", v, c), 16'(Dp_Data), 16'(tbl[v].edp[k]));
            chk($sformatf("vec%0d c%0d fs", v, c), 16'(Frame_Start), 16'(c == 0));
            step();
         end
      end

      // Mid-frame input change must not tear the frame
      Number_Sig = 16'h4321;
      Dp_Sig = 4'h0;
      Zero_Blank_En = 1'b0;
      wait_fs("tear");
      for (int c = 0; c < 16; c++) begin
         if (c == 4) Number_Sig = 16'h8765;
         chk($sformatf("tear c%0d nd", c), 16'(Number_Data), 16'(nib_of(16'h4321, c / 4)));
         step();
      end
      chk("tear next fs", 16'(Frame_Start), 16'h1);
      chk("tear next nd", 16'(Number_Data), 16'h5);

      // PWM dimming; the PWM counter free-runs so any 16-cycle window works
      Number_Sig = 16'h4321;
      Brightness = 4'd4;
      step();
      on_cnt = 0;
      for (int c = 0; c < 16; c++) begin
         if (Digit_Sel32 != 0) on_cnt++;
         chk("pwm32 onehot", 16'($countones(Digit_Sel32) <= 1), 16'h1);
         step();
      end
      chk("pwm32 br4 count", 16'(on_cnt), 16'd4);
      on_cnt = 0;
      for (int c = 0; c < 16; c++) begin
         if (Digit_Sel != 0) on_cnt++;
         step();
      end
      chk("pwm br4 count", 16'(on_cnt), 16'd4);
      Brightness = 4'hE;
      step();
      on_cnt = 0;
      for (int c = 0; c < 16; c++) begin
         if (Digit_Sel32 != 0) on_cnt++;
         step();
      end
      chk("pwm32 brE count", 16'(on_cnt), 16'd14);
      Brightness = 4'd0;
      step();
      on_cnt = 0;
      changed = 0;
      nd_first = Number_Data32;
      for (int c = 0; c < 64; c++) begin
         if (Digit_Sel32 != 0) on_cnt++;
         if (Number_Data32 != nd_first) changed = 1;
         step();
      end
      chk("pwm32 br0 count", 16'(on_cnt), 16'd0);
      chk("pwm32 br0 nd cycles", 16'(changed), 16'h1);
      Brightness = 4'hF;

      // Asynchronous mid-frame reset and fresh restart
      wait_fs("midrst");
      repeat (6) step();
      #3 RST = 1'b1;
      #1;
      chk("midrst sel", 16'(Digit_Sel), 16'h0);
      chk("midrst nd", 16'(Number_Data), 16'h0);
      chk("midrst dp", 16'(Dp_Data), 16'h0);
      chk("midrst fs", 16'(Frame_Start), 16'h0);
      chk("midrst nd32", 16'(Number_Data32), 16'h0);
      Number_Sig = 16'h00A9;
      step();
      chk("midrst held sel", 16'(Digit_Sel), 16'h0);
      @(negedge CLK) RST = 1'b0;
      step();
      chk("restart fs", 16'(Frame_Start), 16'h1);
      chk("restart sel", 16'(Digit_Sel), 16'h1);
      chk("restart nd", 16'(Number_Data), 16'h9);
      repeat (4) step();
      chk("restart slot1 fs", 16'(Frame_Start), 16'h0);
      chk("restart slot1 sel", 16'(Digit_Sel), 16'h2);
      chk("restart slot1 nd", 16'(Number_Data), 16'hA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/smg_scan_ctrl_module.md
SMG_SCAN_CTRL_MODULE -- requirements
Module: smg_scan_ctrl_module

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter SCAN_TICKS, default 50000, CLK cycles per digit slot (1 ms at 50 MHz); legal minimum 2.
REQ-003 Parameter BRIGHT_W, default 4, brightness control width.
REQ-004 CLK  input  1  single clock; all state on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 Number_Sig  input  4*DIGITS  digit k value at [4k+3:4k]; digit 0 is least significant.
REQ-007 Dp_Sig  input  DIGITS  decimal point request, bit k for digit k.
REQ-008 Zero_Blank_En  input  1  enables leading-zero suppression.
REQ-009 Brightness  input  BRIGHT_W  on-time control, 0 = dark, all-ones = full.
REQ-010 Number_Data  output  4  nibble of the currently scanned digit.
REQ-011 Dp_Data  output  1  decimal point of the currently scanned digit.
REQ-012 Digit_Sel  output  DIGITS  one-hot active-high digit enable, all-zero when dark or blanked.
REQ-013 Frame_Start  output  1  one-cycle pulse marking the first cycle of digit 0.

Function
REQ-014 Slot counter SHALL count 0..SCAN_TICKS-1 and wrap; tick = counter at SCAN_TICKS-1.
REQ-015 Digit index SHALL advance by one on each tick and wrap from DIGITS-1 to 0.
REQ-016 Shadow registers SHALL capture Number_Sig, Dp_Sig and Zero_Blank_En on the first CLK edge after RST deasserts and on every wrap edge (tick with index DIGITS-1), and at no other time.
REQ-017 Displayed data SHALL come only from the shadow registers, so input changes mid-frame never tear a frame.
REQ-018 Input-to-display latency SHALL be at most DIGITS*SCAN_TICKS+1 cycles.
REQ-019 Frame_Start SHALL be high for exactly one cycle: the cycle after each shadow load.
REQ-020 Digit k (k>0) SHALL be blanked when shadowed Zero_Blank_En=1 and shadow digits k..DIGITS-1 are all zero; digit 0 is never blanked.
REQ-021 A blanked slot SHALL drive Digit_Sel=0, Number_Data=0 and Dp_Data=0.
REQ-022 A free-running BRIGHT_W-bit PWM counter SHALL increment every CLK and wrap.
REQ-023 A non-blanked slot SHALL drive the one-hot bit of the current index on Digit_Sel when Brightness is all-ones or PWM counter < Brightness; otherwise Digit_Sel=0.
REQ-024 Brightness SHALL be used live, without shadowing; Number_Data and Dp_Data SHALL follow the slot regardless of PWM state.
REQ-025 All outputs SHALL be registered; Digit_Sel SHALL never have more than one bit set.
REQ-026 Nibble values 0..15 SHALL pass through unmodified; decoding belongs to the segment decoder downstream.

Reset
REQ-027 While RST=1, the following SHALL be 0 without waiting for a CLK edge: slot counter, index, PWM counter, shadows, Number_Data, Dp_Data, Digit_Sel and Frame_Start.
REQ-028 Assertion of RST mid-frame SHALL abort the scan immediately; after release, scanning SHALL restart at digit 0 with a fresh shadow load.

Structure
REQ-029 Package smg_pkg SHALL hold the defaults: T1MS=50000, DEF_DIGITS=4 and DEF_BRIGHT_W=4.
REQ-030 The slot counter and tick SHALL be a sub-module named smg_tick_gen, parameterised by SCAN_TICKS.

Verification (DIGITS=4, SCAN_TICKS=4, BRIGHT_W=4 unless stated)
REQ-031 Apply RST, release it with Number_Sig=16'h4321 and Brightness=4'hF. Required response: Digit_Sel runs 0001, 0010, 0100, 1000 for 4 cycles each, with Number_Data 1, 2, 3, 4, and Frame_Start pulses every 16 cycles.
REQ-032 Change Number_Sig to 16'h8765 during the digit-1 slot. Required response: Number_Data finishes 2, 3, 4, then shows 5, 6, 7, 8 after Frame_Start.
REQ-033 Set Zero_Blank_En=1 with Number_Sig=16'h0050. Required response: the digit 3 and digit 2 slots drive Digit_Sel=0; digit 1 shows 5; digit 0 shows 0. With Number_Sig=16'h0000, only the digit-0 slot is lit.
REQ-034 Set SCAN_TICKS=32 with Brightness=4. Required response: Digit_Sel is nonzero for exactly 4 of every 16 cycles. With Brightness=0, Digit_Sel stays 0 while Number_Data keeps cycling.
REQ-035 Set Dp_Sig=4'b0100. Required response: Dp_Data=1 only during the digit-2 slot.
REQ-036 Assert RST between edges in mid-frame. Required response: all outputs go to 0 asynchronously. After release, the first lit slot is digit 0, with Frame_Start pulsing one cycle after release.
